// File: rtl/core_mul_unit_if.sv
// Launch/operand/result bundle between the execute stage (master) and core_mul_unit (slave).
interface core_mul_unit_if;
    logic        start;
    logic        long_mul;
    logic        add;
    logic        signed_mul;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic        ready;
    logic        done;
    logic [31:0] q_hi;
    logic [31:0] q_lo;
    logic        n;
    logic        z;

    modport master (
        output start, long_mul, add, signed_mul, a, b, acc_hi, acc_lo,
        input  ready, done, q_hi, q_lo, n, z
    );

    modport slave (
        input  start, long_mul, add, signed_mul, a, b, acc_hi, acc_lo,
        output ready, done, q_hi, q_lo, n, z
    );
endinterface

// File: rtl/core_mul_unit.sv
// Iterative MUL/MLA/UMULL/SMULL/UMLAL/SMLAL unit retiring STEP_BITS multiplier bits per cycle, then one accumulate cycle.
// Optional MUL_EARLY_TERM_EN: leave the MUL phase as soon as the remaining multiplier bits are all zero.
module core_mul_unit #(
    parameter int STEP_BITS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    core_mul_unit_if.slave  bus
);

    localparam int STEPS = 32 / STEP_BITS;
    localparam int CW    = $clog2(STEPS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [63:0]   a_sh;
    logic [63:0]   prod;
    logic [63:0]   acc;
    logic [63:0]   pp;
    logic [63:0]   prod_fix;
    logic [63:0]   res;
    logic [31:0]   b_mag;
    logic [31:0]   b_nxt;
    logic [31:0]   a_in_mag;
    logic [31:0]   b_in_mag;
    logic          sign;
    logic          long_q;
    logic          sgn_in;
    logic          last_step;
    logic          mul_exit;

    // Signed handling only applies to long ops; short results are sign-agnostic in the low word.
    assign sgn_in   = bus.long_mul & bus.signed_mul;
    assign a_in_mag = (sgn_in & bus.a[31]) ? -bus.a : bus.a;
    assign b_in_mag = (sgn_in & bus.b[31]) ? -bus.b : bus.b;

    assign b_nxt     = b_mag >> STEP_BITS;
    assign pp        = a_sh * 64'(b_mag[STEP_BITS-1:0]);
    assign last_step = (cnt == CW'(STEPS - 1));
    assign prod_fix  = sign ? -prod : prod;
    assign res       = prod_fix + acc;
    assign bus.ready = (state == IDLE);

`ifdef MUL_EARLY_TERM_EN
    assign mul_exit = last_step || (b_nxt == 32'd0);
`else
    assign mul_exit = last_step;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = MUL;
            MUL:     if (mul_exit)  state_nxt = ACC;
            ACC:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            a_sh     <= '0;
            b_mag    <= '0;
            prod     <= '0;
            acc      <= '0;
            sign     <= 1'b0;
            long_q   <= 1'b0;
            bus.done <= 1'b0;
            bus.q_hi <= '0;
            bus.q_lo <= '0;
            bus.n    <= 1'b0;
            bus.z    <= 1'b0;
        end else begin
            bus.done <= (state == ACC);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt    <= '0;
                        a_sh   <= {32'd0, a_in_mag};
                        b_mag  <= b_in_mag;
                        prod   <= '0;
                        sign   <= sgn_in & (bus.a[31] ^ bus.b[31]);
                        long_q <= bus.long_mul;
                        if (!bus.add)         acc <= '0;
                        else if (bus.long_mul) acc <= {bus.acc_hi, bus.acc_lo};
                        else                  acc <= {32'd0, bus.acc_lo};
                    end
                end
                MUL: begin
                    prod  <= prod + pp;
                    a_sh  <= a_sh << STEP_BITS;
                    b_mag <= b_nxt;
                    cnt   <= cnt + CW'(1);
                end
                ACC: begin
                    bus.q_hi <= long_q ? res[63:32] : 32'd0;
                    bus.q_lo <= res[31:0];
                    bus.n    <= long_q ? res[63] : res[31];
                    bus.z    <= long_q ? (res == 64'd0) : (res[31:0] == 32'd0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_mul_unit.sv
// Self-checking bench for core_mul_unit: directed vectors, randomized ops against an arithmetic model, busy/back-to-back/reset cases.
module tb_core_mul_unit;

    localparam int SB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    core_mul_unit_if bus();

    core_mul_unit #(.STEP_BITS(SB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Full-precision arithmetic reference.
    function automatic logic [63:0] model_result(input logic lm, input logic ad, input logic sg,
                                                 input logic [31:0] a, input logic [31:0] b,
                                                 input logic [31:0] ah, input logic [31:0] al);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [31:0] s32;
        if (lm && sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = 64'(sa * sb);
        end else begin
            p = {32'd0, a} * {32'd0, b};
        end
        if (lm) return p + (ad ? {ah, al} : 64'd0);
        s32 = p[31:0] + (ad ? al : 32'd0);
        return {32'd0, s32};
    endfunction

    function automatic int exp_lat(input logic lm, input logic sg, input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
        logic [31:0] bm;
        int          msb;
        bm  = (lm && sg && b[31]) ? (~b + 32'd1) : b;
        msb = -1;
        for (int i = 0; i < 32; i++) if (bm[i]) msb = i;
        if (msb < 0) return 2;
        return (msb + SB) / SB + 1;
`else
        return 32 / SB + 1;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Launch one op from a post-edge point; returns at the done cycle (or timeout, lat=-1).
    task automatic run_op(input logic lm, input logic ad, input logic sg,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ah, input logic [31:0] al, input logic hold_start,
                          output int lat, output logic [31:0] qh, output logic [31:0] ql,
                          output logic nn, output logic zz);
        bus.start = 1'b1; bus.long_mul = lm; bus.add = ad; bus.signed_mul = sg;
        bus.a = a; bus.b = b; bus.acc_hi = ah; bus.acc_lo = al;
        @(posedge clk); #1;
        bus.start = hold_start;
        bus.long_mul = 1'($urandom); bus.add = 1'($urandom); bus.signed_mul = 1'($urandom);
        bus.a = $urandom; bus.b = $urandom; bus.acc_hi = $urandom; bus.acc_lo = $urandom;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        bus.start = 1'b0;
        qh = bus.q_hi; ql = bus.q_lo; nn = bus.n; zz = bus.z;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.ready, bus.done, bus.q_hi, bus.q_lo, bus.n, bus.z} !== {1'b1, 1'b0, 64'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b done=%b q=%h_%h n=%b z=%b required rdy=1 done=0 q=0 n=0 z=0",
                     bus.ready, bus.done, bus.q_hi, bus.q_lo, bus.n, bus.z);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] va [5] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] vb [5] = '{32'd6, 32'd2, 32'd5, 32'hFFFF_FFFF, 32'h1234_5678};
        logic [31:0] vl [5] = '{32'd0, 32'd3, 32'd0, 32'd1, 32'd0};
        logic        vlm[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        vad[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        vsg[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [65:0] ex [5] = '{{64'h0000_0000_0000_002A, 1'b0, 1'b0},
                                {64'h0000_0000_0000_0001, 1'b0, 1'b0},
                                {64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 1'b0},
                                {64'hFFFF_FFFE_0000_0002, 1'b1, 1'b0},
                                {64'h0000_0000_0000_0000, 1'b0, 1'b1}};
        int lat; logic [31:0] qh, ql; logic nn, zz;
        for (int k = 0; k < 5; k++) begin
            run_op(vlm[k], vad[k], vsg[k], va[k], vb[k], 32'd0, vl[k], 1'b0, lat, qh, ql, nn, zz);
            checks++;
            if ({qh, ql, nn, zz} !== ex[k]) begin
                errors++;
                $display("FAIL directed_%0d: got q=%h_%h n=%b z=%b required %h", k, qh, ql, nn, zz, ex[k]);
            end
            checks++;
            if (lat !== exp_lat(vlm[k], vsg[k], vb[k])) begin
                errors++;
                $display("FAIL directed_lat_%0d: got %0d required %0d", k, lat, exp_lat(vlm[k], vsg[k], vb[k]));
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] qh, ql, a, b, ah, al; logic nn, zz, lm, ad, sg;
        logic [63:0] r; logic [31:0] eh; logic en, ez;
        for (int k = 0; k < 40; k++) begin
            lm = 1'($urandom); ad = 1'($urandom); sg = 1'($urandom);
            a = pick(); b = pick(); ah = pick(); al = pick();
            r  = model_result(lm, ad, sg, a, b, ah, al);
            eh = lm ? r[63:32] : 32'd0;
            en = lm ? r[63] : r[31];
            ez = lm ? (r == 64'd0) : (r[31:0] == 32'd0);
            run_op(lm, ad, sg, a, b, ah, al, 1'b0, lat, qh, ql, nn, zz);
            checks++;
            if ({qh, ql, nn, zz, lat} !== {eh, r[31:0], en, ez, exp_lat(lm, sg, b)}) begin
                errors++;
                $display("FAIL random_%0d: lm=%b ad=%b sg=%b a=%h b=%h acc=%h_%h got q=%h_%h n=%b z=%b lat=%0d required q=%h_%h n=%b z=%b lat=%0d",
                         k, lm, ad, sg, a, b, ah, al, qh, ql, nn, zz, lat, eh, r[31:0], en, ez, exp_lat(lm, sg, b));
            end
            @(posedge clk); #1;
            checks++;
            if ({bus.done, bus.q_hi, bus.q_lo, bus.n, bus.z} !== {1'b0, qh, ql, nn, zz}) begin
                errors++;
                $display("FAIL hold_%0d: got done=%b q=%h_%h required done=0 q=%h_%h",
                         k, bus.done, bus.q_hi, bus.q_lo, qh, ql);
            end
        end
    endtask

    task automatic test_busy();
        int lat, seen; logic [31:0] qh, ql; logic nn, zz;
        run_op(1'b0, 1'b1, 1'b0, 32'd1000, 32'd3, 32'd0, 32'd5, 1'b1, lat, qh, ql, nn, zz);
        checks++;
        if ({lat, ql, qh} !== {exp_lat(1'b0, 1'b0, 32'd3), 32'd3005, 32'd0}) begin
            errors++;
            $display("FAIL busy_op: got lat=%0d q_lo=%0d required lat=%0d q_lo=3005", lat, ql, exp_lat(1'b0, 1'b0, 32'd3));
        end
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (bus.done || !bus.ready) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL busy_single: got %0d extra busy/done cycles required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] qh, ql; logic nn, zz;
        run_op(1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 1'b0, lat, qh, ql, nn, zz);
        checks++;
        if ({bus.ready, qh, ql} !== {1'b1, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL b2b_first: got rdy=%b q=%h_%h required rdy=1 q=00000001_00000000", bus.ready, qh, ql);
        end
        run_op(1'b0, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, lat, qh, ql, nn, zz);
        checks++;
        if ({lat, qh, ql} !== {exp_lat(1'b0, 1'b0, 32'd9), 32'd0, 32'd81}) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d q=%h_%h required lat=%0d q=0_81",
                     lat, qh, ql, exp_lat(1'b0, 1'b0, 32'd9));
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        bus.start = 1'b1; bus.long_mul = 1'b0; bus.add = 1'b0; bus.signed_mul = 1'b0;
        bus.a = 32'd123; bus.b = 32'd456;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ready, bus.done, bus.q_hi, bus.q_lo, bus.n, bus.z} !== {1'b1, 1'b0, 64'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_op: got rdy=%b done=%b q=%h_%h n=%b z=%b required rdy=1 done=0 q=0 n=0 z=0",
                     bus.ready, bus.done, bus.q_hi, bus.q_lo, bus.n, bus.z);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (bus.done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d done pulses required 0", seen);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.long_mul = 1'b0; bus.add = 1'b0; bus.signed_mul = 1'b0;
        bus.a = '0; bus.b = '0; bus.acc_hi = '0; bus.acc_lo = '0;
        test_reset();
        test_directed();
        test_random();
        test_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
